// File: rtl/chacha_pkg.sv
// chacha_pkg: shared constants and types for the ChaCha block datapath.
//   CHACHA_WORDS / CHACHA_WORD_W : state geometry (16 x 32-bit words)
//   SIGMA_0..3                   : "expand 32-byte k" constants for the formatter
//   chacha_state_e               : round controller FSM encoding
//   QR_COL_IDX / QR_DIAG_IDX     : quarterround operand index tables
//   qr_idx()                     : table lookup helper
//   rotl32()                     : 32-bit rotate-left
package chacha_pkg;

    localparam int unsigned CHACHA_WORDS  = 16;
    localparam int unsigned CHACHA_WORD_W = 32;

    localparam logic [31:0] SIGMA_0 = 32'h6170_7865;
    localparam logic [31:0] SIGMA_1 = 32'h3320_646e;
    localparam logic [31:0] SIGMA_2 = 32'h7962_2d32;
    localparam logic [31:0] SIGMA_3 = 32'h6b20_6574;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_FINAL = 2'd2
    } chacha_state_e;

    // Entry for (lane, operand) sits in nibble 15-{lane,operand}, i.e. the
    // tables read left-to-right as lane0:a,b,c,d  lane1:a,b,c,d ...
    localparam logic [63:0] QR_COL_IDX = {
        4'd0, 4'd4, 4'd8,  4'd12,
        4'd1, 4'd5, 4'd9,  4'd13,
        4'd2, 4'd6, 4'd10, 4'd14,
        4'd3, 4'd7, 4'd11, 4'd15
    };

    localparam logic [63:0] QR_DIAG_IDX = {
        4'd0, 4'd5, 4'd10, 4'd15,
        4'd1, 4'd6, 4'd11, 4'd12,
        4'd2, 4'd7, 4'd8,  4'd13,
        4'd3, 4'd4, 4'd9,  4'd14
    };

    function automatic logic [3:0] qr_idx(input logic diag,
                                          input logic [1:0] lane,
                                          input logic [1:0] pos);
        logic [63:0] tbl;
        logic [3:0]  slot_rev;
        tbl      = diag ? QR_DIAG_IDX : QR_COL_IDX;
        slot_rev = ~{lane, pos};
        return tbl[{slot_rev, 2'b00} +: 4];
    endfunction

    function automatic logic [31:0] rotl32(input logic [31:0] x,
                                           input int unsigned n);
        return (x << n) | (x >> (32 - n));
    endfunction

endpackage

// File: rtl/chacha_qr.sv
// chacha_qr: combinational ChaCha quarterround.
//   a_in..d_in   : input words
//   a_out..d_out : quarterround results
module chacha_qr
    import chacha_pkg::*;
(
    input  logic [CHACHA_WORD_W-1:0] a_in,
    input  logic [CHACHA_WORD_W-1:0] b_in,
    input  logic [CHACHA_WORD_W-1:0] c_in,
    input  logic [CHACHA_WORD_W-1:0] d_in,
    output logic [CHACHA_WORD_W-1:0] a_out,
    output logic [CHACHA_WORD_W-1:0] b_out,
    output logic [CHACHA_WORD_W-1:0] c_out,
    output logic [CHACHA_WORD_W-1:0] d_out
);

    logic [CHACHA_WORD_W-1:0] a1, b1, c1, d1;
    logic [CHACHA_WORD_W-1:0] a2, b2, c2, d2;

    always_comb begin
        a1 = a_in + b_in;
        d1 = rotl32(d_in ^ a1, 16);
        c1 = c_in + d1;
        b1 = rotl32(b_in ^ c1, 12);
        a2 = a1 + b1;
        d2 = rotl32(d1 ^ a2, 8);
        c2 = c1 + d2;
        b2 = rotl32(b1 ^ c2, 7);
    end

    assign a_out = a2;
    assign b_out = b2;
    assign c_out = c2;
    assign d_out = d2;

endmodule

// File: rtl/chacha_round_ctrl.sv
// chacha_round_ctrl: ChaCha block-function sequencer.
//   ROUNDS     : half-rounds per block (8, 12 or 20)
//   clk        : clock, rising edge
//   reset_n    : asynchronous active-low reset
//   start      : process state_in, sampled while ready
//   state_in   : 16-word input state, word i at [511-32*i -: 32]
//   ready      : idle, will accept start
//   data_out   : keystream block, same word order as state_in
//   data_valid : data_out holds a completed block
module chacha_round_ctrl
    import chacha_pkg::*;
#(
    parameter int unsigned ROUNDS = 20
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [511:0] state_in,
    output logic         ready,
    output logic [511:0] data_out,
    output logic         data_valid
);

    if (!(ROUNDS == 8 || ROUNDS == 12 || ROUNDS == 20)) begin : g_rounds_check
        $error("chacha_round_ctrl: ROUNDS must be 8, 12 or 20");
    end

    localparam logic [4:0] LAST_HALF = 5'(ROUNDS - 1);

    chacha_state_e            state;
    logic [CHACHA_WORD_W-1:0] in_reg   [CHACHA_WORDS];
    logic [CHACHA_WORD_W-1:0] work     [CHACHA_WORDS];
    logic [CHACHA_WORD_W-1:0] work_nxt [CHACHA_WORDS];
    logic [4:0]               round_ctr;
    logic                     diag;
    logic [511:0]             final_sum;

    logic [CHACHA_WORD_W-1:0] qa [4];
    logic [CHACHA_WORD_W-1:0] qb [4];
    logic [CHACHA_WORD_W-1:0] qc [4];
    logic [CHACHA_WORD_W-1:0] qd [4];
    logic [CHACHA_WORD_W-1:0] ra [4];
    logic [CHACHA_WORD_W-1:0] rb [4];
    logic [CHACHA_WORD_W-1:0] rc [4];
    logic [CHACHA_WORD_W-1:0] rd [4];

    assign diag = round_ctr[0];

    // Operand select: every lane picks its four words from the column or
    // diagonal table; the lanes of one half-round touch disjoint words.
    always_comb begin
        for (int unsigned lane = 0; lane < 4; lane++) begin
            qa[lane] = work[qr_idx(diag, 2'(lane), 2'd0)];
            qb[lane] = work[qr_idx(diag, 2'(lane), 2'd1)];
            qc[lane] = work[qr_idx(diag, 2'(lane), 2'd2)];
            qd[lane] = work[qr_idx(diag, 2'(lane), 2'd3)];
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_qr
        chacha_qr u_qr (
            .a_in  (qa[g]),
            .b_in  (qb[g]),
            .c_in  (qc[g]),
            .d_in  (qd[g]),
            .a_out (ra[g]),
            .b_out (rb[g]),
            .c_out (rc[g]),
            .d_out (rd[g])
        );
    end

    // Scatter results back to the same indices they were gathered from.
    always_comb begin
        work_nxt = work;
        for (int unsigned lane = 0; lane < 4; lane++) begin
            work_nxt[qr_idx(diag, 2'(lane), 2'd0)] = ra[lane];
            work_nxt[qr_idx(diag, 2'(lane), 2'd1)] = rb[lane];
            work_nxt[qr_idx(diag, 2'(lane), 2'd2)] = rc[lane];
            work_nxt[qr_idx(diag, 2'(lane), 2'd3)] = rd[lane];
        end
    end

    always_comb begin
        final_sum = '0;
        for (int unsigned i = 0; i < CHACHA_WORDS; i++) begin
            final_sum[511 - 32*i -: 32] = work[i] + in_reg[i];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            ready      <= 1'b1;
            data_valid <= 1'b0;
            data_out   <= '0;
            round_ctr  <= '0;
            for (int unsigned i = 0; i < CHACHA_WORDS; i++) begin
                work[i]   <= '0;
                in_reg[i] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        for (int unsigned i = 0; i < CHACHA_WORDS; i++) begin
                            in_reg[i] <= state_in[511 - 32*i -: 32];
                            work[i]   <= state_in[511 - 32*i -: 32];
                        end
                        round_ctr  <= '0;
                        data_valid <= 1'b0;
                        ready      <= 1'b0;
                        state      <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    work <= work_nxt;
                    // Counter parks at the last half-round rather than wrapping.
                    if (round_ctr == LAST_HALF) begin
                        state <= ST_FINAL;
                    end else begin
                        round_ctr <= round_ctr + 5'd1;
                    end
                end
                ST_FINAL: begin
                    data_out   <= final_sum;
                    data_valid <= 1'b1;
                    ready      <= 1'b1;
                    state      <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chacha_round_ctrl.sv
module tb_chacha_round_ctrl;
    import chacha_pkg::*;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start_v      [3];
    logic [511:0] state_v      [3];
    logic         ready_v      [3];
    logic [511:0] data_out_v   [3];
    logic         data_valid_v [3];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    chacha_round_ctrl #(.ROUNDS(20)) dut20 (
        .clk(clk), .reset_n(reset_n), .start(start_v[0]), .state_in(state_v[0]),
        .ready(ready_v[0]), .data_out(data_out_v[0]), .data_valid(data_valid_v[0])
    );
    chacha_round_ctrl #(.ROUNDS(12)) dut12 (
        .clk(clk), .reset_n(reset_n), .start(start_v[1]), .state_in(state_v[1]),
        .ready(ready_v[1]), .data_out(data_out_v[1]), .data_valid(data_valid_v[1])
    );
    chacha_round_ctrl #(.ROUNDS(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .start(start_v[2]), .state_in(state_v[2]),
        .ready(ready_v[2]), .data_out(data_out_v[2]), .data_valid(data_valid_v[2])
    );

    function automatic logic [31:0] rl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [511:0] ref_block(input logic [511:0] s, input int rounds);
        logic [31:0]  x   [16];
        logic [31:0]  ini [16];
        logic [511:0] r;
        int a, b, c, d;
        for (int i = 0; i < 16; i++) begin
            x[i]   = s[511 - 32*i -: 32];
            ini[i] = x[i];
        end
        for (int h = 0; h < rounds; h++) begin
            for (int l = 0; l < 4; l++) begin
                a = l;
                if (h % 2 == 0) begin
                    b = 4 + l; c = 8 + l; d = 12 + l;
                end else begin
                    b = 4 + (l + 1) % 4; c = 8 + (l + 2) % 4; d = 12 + (l + 3) % 4;
                end
                x[a] = x[a] + x[b]; x[d] = rl(x[d] ^ x[a], 16);
                x[c] = x[c] + x[d]; x[b] = rl(x[b] ^ x[c], 12);
                x[a] = x[a] + x[b]; x[d] = rl(x[d] ^ x[a], 8);
                x[c] = x[c] + x[d]; x[b] = rl(x[b] ^ x[c], 7);
            end
        end
        r = '0;
        for (int i = 0; i < 16; i++) r[511 - 32*i -: 32] = x[i] + ini[i];
        return r;
    endfunction

    function automatic logic [31:0] word(input logic [511:0] blk, input int i);
        return blk[511 - 32*i -: 32];
    endfunction

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse start on one instance and follow the block to data_valid.
    // lat counts edges after the accepting edge; low counts cycles with ready=0.
    task automatic run(input int sel, input logic [511:0] st, input logic busy,
                       output int lat, output int low,
                       output logic dv_acc, output logic [511:0] dout_acc);
        state_v[sel] = st;
        start_v[sel] = 1'b1;
        @(posedge clk); #1;
        start_v[sel] = 1'b0;
        dv_acc   = data_valid_v[sel];
        dout_acc = data_out_v[sel];
        low = ready_v[sel] ? 0 : 1;
        lat = 0;
        while (lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (busy && lat == 3) begin
                start_v[sel] = 1'b1;
                state_v[sel] = '0;
            end else if (busy && lat == 4) begin
                start_v[sel] = 1'b0;
            end
            if (data_valid_v[sel]) break;
            if (!ready_v[sel]) low++;
        end
    endtask

    logic [511:0] zero_key;
    logic [511:0] rfc_in;
    logic [511:0] rfc_exp;
    logic [511:0] zk_exp20;
    int           lat, low;
    logic         dv_acc;
    logic [511:0] dout_acc;

    initial begin
        zero_key = {SIGMA_0, SIGMA_1, SIGMA_2, SIGMA_3, 384'd0};
        rfc_in   = {SIGMA_0, SIGMA_1, SIGMA_2, SIGMA_3,
                    32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c,
                    32'h13121110, 32'h17161514, 32'h1b1a1918, 32'h1f1e1d1c,
                    32'h00000001, 32'h09000000, 32'h4a000000, 32'h00000000};
        rfc_exp  = ref_block(rfc_in, 20);
        zk_exp20 = ref_block(zero_key, 20);

        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0;
            state_v[i] = '0;
        end
        reset_n = 1'b0;
        #12;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset_ready%0d", i), 512'(ready_v[i]), 512'd1);
            chk($sformatf("reset_valid%0d", i), 512'(data_valid_v[i]), 512'd0);
            chk($sformatf("reset_dout%0d", i), data_out_v[i], 512'd0);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;

        // All-zero input
        run(0, 512'd0, 1'b0, lat, low, dv_acc, dout_acc);
        chk("zero_latency", 512'(lat), 512'd21);
        chk("zero_ready_low", 512'(low), 512'd21);
        chk("zero_dout", data_out_v[0], 512'd0);

        // Zero key/nonce/counter
        run(0, zero_key, 1'b0, lat, low, dv_acc, dout_acc);
        chk("zk_latency", 512'(lat), 512'd21);
        chk("zk_w0", 512'(word(data_out_v[0], 0)), 512'(32'hade0b876));
        chk("zk_w1", 512'(word(data_out_v[0], 1)), 512'(32'h903df1a0));
        chk("zk_model", data_out_v[0], zk_exp20);

        // RFC 8439 block with an ignored start pulse during ROUND
        run(0, rfc_in, 1'b1, lat, low, dv_acc, dout_acc);
        chk("rfc_latency", 512'(lat), 512'd21);
        chk("rfc_ready_low", 512'(low), 512'd21);
        chk("rfc_w0", 512'(word(data_out_v[0], 0)), 512'(32'he4e7f110));
        chk("rfc_w1", 512'(word(data_out_v[0], 1)), 512'(32'h15593bd1));
        chk("rfc_w15", 512'(word(data_out_v[0], 15)), 512'(32'h4e3c50a2));
        chk("rfc_model", data_out_v[0], rfc_exp);
        chk("rfc_valid_ready", 512'(ready_v[0]), 512'd1);

        // Back-to-back: start on the edge right after data_valid rose
        run(0, zero_key, 1'b0, lat, low, dv_acc, dout_acc);
        chk("b2b_valid_cleared", 512'(dv_acc), 512'd0);
        chk("b2b_dout_stale", dout_acc, rfc_exp);
        chk("b2b_latency", 512'(lat), 512'd21);
        chk("b2b_ready_low", 512'(low), 512'd21);
        chk("b2b_w0", 512'(word(data_out_v[0], 0)), 512'(32'hade0b876));

        // Reset after half-round 7 of a block
        state_v[0] = zero_key;
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        chk("mid_busy", 512'(ready_v[0]), 512'd0);
        repeat (7) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("mid_reset_ready", 512'(ready_v[0]), 512'd1);
        chk("mid_reset_valid", 512'(data_valid_v[0]), 512'd0);
        chk("mid_reset_dout", data_out_v[0], 512'd0);
        #2 reset_n = 1'b1;
        @(posedge clk); #1;
        run(0, rfc_in, 1'b0, lat, low, dv_acc, dout_acc);
        chk("post_reset_latency", 512'(lat), 512'd21);
        chk("post_reset_model", data_out_v[0], rfc_exp);
        chk("post_reset_w15", 512'(word(data_out_v[0], 15)), 512'(32'h4e3c50a2));

        // ROUNDS=12
        run(1, zero_key, 1'b0, lat, low, dv_acc, dout_acc);
        chk("r12_latency", 512'(lat), 512'd13);
        chk("r12_ready_low", 512'(low), 512'd13);
        chk("r12_w0", 512'(word(data_out_v[1], 0)), 512'(32'h6a9af49b));
        chk("r12_w1", 512'(word(data_out_v[1], 1)), 512'(32'h53f95507));
        chk("r12_model", data_out_v[1], ref_block(zero_key, 12));

        // ROUNDS=8
        run(2, zero_key, 1'b0, lat, low, dv_acc, dout_acc);
        chk("r8_latency", 512'(lat), 512'd9);
        chk("r8_ready_low", 512'(low), 512'd9);
        chk("r8_w0", 512'(word(data_out_v[2], 0)), 512'(32'h2fef003e));
        chk("r8_w1", 512'(word(data_out_v[2], 1)), 512'(32'hd6405f89));
        chk("r8_model", data_out_v[2], ref_block(zero_key, 8));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
